// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BIT_COUNT = 8
);
    logic [NUM_CH-1:0]                req_valid;
    logic [NUM_CH*DATA_BIT_COUNT-1:0] req_data;
    logic [NUM_CH-1:0]                req_ready;
    logic [DATA_BIT_COUNT-1:0]        tx_data;
    logic                             tx_data_ready;
    logic                             tx_done;

    // master is the arbiter side, slave is the sources plus the serializer
    modport master (
        input  req_valid, req_data, tx_done,
        output req_ready, tx_data, tx_data_ready
    );
    modport slave (
        output req_valid, req_data, tx_done,
        input  req_ready, tx_data, tx_data_ready
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding one uart_tx, with channel tag bytes
module uart_tx_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BIT_COUNT = 8,
    parameter int MAX_BURST      = 16,
    parameter int TAG_EN         = 1,
    parameter int TAG_BASE       = 'h30
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_tx_arbiter_if.master         bus,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      busy
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int DW   = DATA_BIT_COUNT;
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE
    } state_t;

    state_t         state;
    logic [CH_W-1:0] last_owner;
    logic [CH_W-1:0] tagged_ch;
    logic [BW-1:0]  burst_cnt;
    logic           tag_valid;
    logic           tag_pending;

    logic            scan_hit;
    logic [CH_W-1:0] scan_sel;
    logic [CH_W-1:0] cand;
    logic            take;
    logic            start_tag;
    logic            new_grant;
    logic [CH_W-1:0] take_ch;
    logic [DW-1:0]   payload;
    logic [DW-1:0]   tag_byte;

    // Scan from the farthest candidate down so the nearest valid channel after last_owner wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_sel = last_owner;
        cand     = last_owner;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = CH_W'((int'(last_owner) + k) % NUM_CH);
            if (bus.req_valid[cand]) begin
                scan_hit = 1'b1;
                scan_sel = cand;
            end
        end
    end

    // The decision is held off during reset so req_ready cannot leak a pop while rst_n is low.
    always_comb begin
        take      = 1'b0;
        start_tag = 1'b0;
        new_grant = 1'b0;
        take_ch   = grant_id;
        if (rst_n && state == S_IDLE && bus.tx_done) begin
            if (tag_pending) begin
                take = bus.req_valid[grant_id];
            end else if (bus.req_valid[last_owner] && burst_cnt != '0 && burst_cnt < BURST_MAX) begin
                take    = 1'b1;
                take_ch = last_owner;
            end else if (scan_hit) begin
                new_grant = 1'b1;
                take_ch   = scan_sel;
                if (TAG_EN != 0 && (!tag_valid || scan_sel != tagged_ch)) begin
                    start_tag = 1'b1;
                end else begin
                    take = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (take) begin
            bus.req_ready[take_ch] = 1'b1;
        end
        payload  = bus.req_data[int'(take_ch)*DATA_BIT_COUNT +: DATA_BIT_COUNT];
        tag_byte = DW'(TAG_BASE + int'(take_ch));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            bus.tx_data       <= '0;
            bus.tx_data_ready <= 1'b0;
            grant_id          <= '0;
            busy              <= 1'b0;
            last_owner        <= CH_W'(NUM_CH - 1);
            tagged_ch         <= '0;
            burst_cnt         <= '0;
            tag_valid         <= 1'b0;
            tag_pending       <= 1'b0;
        end else begin
            bus.tx_data_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (take || start_tag) begin
                        state             <= S_ISSUE;
                        busy              <= 1'b1;
                        bus.tx_data_ready <= 1'b1;
                        if (new_grant) begin
                            grant_id   <= take_ch;
                            last_owner <= take_ch;
                        end
                        if (start_tag) begin
                            bus.tx_data <= tag_byte;
                            tagged_ch   <= take_ch;
                            tag_valid   <= 1'b1;
                            tag_pending <= 1'b1;
                        end else begin
                            bus.tx_data <= payload;
                            tag_pending <= 1'b0;
                            if (new_grant || tag_pending) begin
                                burst_cnt <= BW'(1);
                            end else if (burst_cnt < BURST_MAX) begin
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_ACC;
                end
                S_WAIT_ACC: begin
                    if (!bus.tx_done) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural uart_tx
module tb_uart_tx_arbiter;
    localparam int FRAME = 40;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_v     [2];
    logic [3:0]  req_valid_v [2];
    logic [31:0] req_data_v  [2];
    logic        tx_done_v   [2];
    logic [3:0]  rr_now      [2];
    logic [3:0]  rr_q        [2];
    logic        tx_rdy_v    [2];
    logic [7:0]  tx_data_v   [2];
    logic [1:0]  grant_v     [2];
    logic        busy_v      [2];
    logic [1:0]  grant_a, grant_b;
    logic        busy_a, busy_b;

    uart_tx_arbiter_if #(.NUM_CH(4), .DATA_BIT_COUNT(8)) bus_a ();
    uart_tx_arbiter_if #(.NUM_CH(4), .DATA_BIT_COUNT(8)) bus_b ();

    uart_tx_arbiter #(.NUM_CH(4), .DATA_BIT_COUNT(8), .MAX_BURST(2), .TAG_EN(1), .TAG_BASE('h30)) dut_a (
        .clk(clk), .rst_n(rst_n_v[0]), .bus(bus_a.master), .grant_id(grant_a), .busy(busy_a)
    );
    uart_tx_arbiter #(.NUM_CH(4), .DATA_BIT_COUNT(8), .MAX_BURST(1), .TAG_EN(0), .TAG_BASE('h30)) dut_b (
        .clk(clk), .rst_n(rst_n_v[1]), .bus(bus_b.master), .grant_id(grant_b), .busy(busy_b)
    );

    assign bus_a.req_valid = req_valid_v[0];
    assign bus_a.req_data  = req_data_v[0];
    assign bus_a.tx_done   = tx_done_v[0];
    assign bus_b.req_valid = req_valid_v[1];
    assign bus_b.req_data  = req_data_v[1];
    assign bus_b.tx_done   = tx_done_v[1];
    assign rr_now[0]    = bus_a.req_ready;
    assign rr_now[1]    = bus_b.req_ready;
    assign tx_rdy_v[0]  = bus_a.tx_data_ready;
    assign tx_rdy_v[1]  = bus_b.tx_data_ready;
    assign tx_data_v[0] = bus_a.tx_data;
    assign tx_data_v[1] = bus_b.tx_data;
    assign grant_v[0]   = grant_a;
    assign grant_v[1]   = grant_b;
    assign busy_v[0]    = busy_a;
    assign busy_v[1]    = busy_b;

    always @(posedge clk) begin
        rr_q[0] <= rr_now[0];
        rr_q[1] <= rr_now[1];
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] src_mem  [2][4][16];
    int         src_wr   [2][4];
    int         src_rd   [2][4];
    logic [7:0] etx_mem  [2][64];
    int         etx_wr   [2];
    int         etx_rd   [2];
    int         eacc_mem [2][32];
    int         eacc_wr  [2];
    int         eacc_rd  [2];
    int         ucnt     [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int d, input logic [7:0] b);
        etx_mem[d][etx_wr[d]] = b;
        etx_wr[d]++;
    endtask

    task automatic push_acc(input int d, input int ch);
        eacc_mem[d][eacc_wr[d]] = ch;
        eacc_wr[d]++;
    endtask

    task automatic push_src(input int d, input int ch, input logic [7:0] b);
        src_mem[d][ch][src_wr[d][ch] % 16] = b;
        src_wr[d][ch]++;
    endtask

    task automatic wait_idle(input int d, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(etx_rd[d] == etx_wr[d] && eacc_rd[d] == eacc_wr[d] &&
                     busy_v[d] == 1'b0 && tx_done_v[d] == 1'b1) && n < BUDGET);
        chk({name, "_drained"}, 32'(n < BUDGET), 1);
    endtask

    // Monitor: accepted-byte scoreboard, behavioural uart_tx, and the byte sources.
    initial begin
        for (int d = 0; d < 2; d++) begin
            tx_done_v[d]   = 1'b1;
            ucnt[d]        = 0;
            req_valid_v[d] = '0;
            req_data_v[d]  = '0;
            etx_wr[d] = 0; etx_rd[d] = 0; eacc_wr[d] = 0; eacc_rd[d] = 0;
            for (int c = 0; c < 4; c++) begin
                src_wr[d][c] = 0;
                src_rd[d][c] = 0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rr_q[d] != 4'b0) begin
                    chk("acc_expected_avail", 32'(eacc_rd[d] < eacc_wr[d]), 1);
                    chk("acc_onehot", 32'($onehot(rr_q[d])), 1);
                    if (eacc_rd[d] < eacc_wr[d]) begin
                        chk($sformatf("acc_ch_dut%0d", d), 32'(rr_q[d]), 32'(1) << eacc_mem[d][eacc_rd[d]]);
                        eacc_rd[d]++;
                    end
                    for (int c = 0; c < 4; c++) begin
                        if (rr_q[d][c]) src_rd[d][c]++;
                    end
                end
                if (tx_rdy_v[d]) begin
                    chk("tx_ready_while_busy", 32'(tx_done_v[d]), 1);
                    chk("tx_expected_avail", 32'(etx_rd[d] < etx_wr[d]), 1);
                    if (etx_rd[d] < etx_wr[d]) begin
                        chk($sformatf("tx_byte_dut%0d_n%0d", d, etx_rd[d]), 32'(tx_data_v[d]), 32'(etx_mem[d][etx_rd[d]]));
                        etx_rd[d]++;
                    end
                    ucnt[d]      = FRAME;
                    tx_done_v[d] = 1'b0;
                end else if (ucnt[d] > 0) begin
                    ucnt[d]--;
                    if (ucnt[d] == 0) tx_done_v[d] = 1'b1;
                end
                for (int c = 0; c < 4; c++) begin
                    req_valid_v[d][c]          = (src_rd[d][c] < src_wr[d][c]);
                    req_data_v[d][c*8 +: 8]    = src_mem[d][c][src_rd[d][c] % 16];
                end
            end
        end
    end

    initial begin
        int n;
        rst_n_v[0] = 1'b0;
        rst_n_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_v[0] = 1'b1;
        rst_n_v[1] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", 32'(busy_v[d]), 0);
            chk("reset_grant", 32'(grant_v[d]), 0);
            chk("reset_tx_data_ready", 32'(tx_rdy_v[d]), 0);
            chk("reset_tx_data", 32'(tx_data_v[d]), 0);
            chk("reset_req_ready", 32'(rr_now[d]), 0);
        end

        // first byte after reset is tagged
        @(posedge clk);
        push_exp(0, 8'h31); push_exp(0, 8'h41); push_acc(0, 1);
        push_src(0, 1, 8'h41);
        wait_idle(0, "t1");
        chk("t1_grant", 32'(grant_v[0]), 1);

        // same owner continues untagged
        @(posedge clk);
        push_exp(0, 8'h42); push_acc(0, 1);
        push_src(0, 1, 8'h42);
        wait_idle(0, "t2");
        chk("t2_grant", 32'(grant_v[0]), 1);

        rst_n_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_v[0] = 1'b1;

        // ch0 and ch2 both streaming, bursts of 2
        @(posedge clk);
        push_exp(0, 8'h30); push_exp(0, 8'hA0); push_exp(0, 8'hA1);
        push_exp(0, 8'h32); push_exp(0, 8'hC0); push_exp(0, 8'hC1);
        push_exp(0, 8'h30); push_exp(0, 8'hA2); push_exp(0, 8'hA3);
        push_exp(0, 8'h32); push_exp(0, 8'hC2); push_exp(0, 8'hC3);
        push_acc(0, 0); push_acc(0, 0); push_acc(0, 2); push_acc(0, 2);
        push_acc(0, 0); push_acc(0, 0); push_acc(0, 2); push_acc(0, 2);
        for (int i = 0; i < 4; i++) begin
            push_src(0, 0, 8'hA0 + 8'(i));
            push_src(0, 2, 8'hC0 + 8'(i));
        end
        wait_idle(0, "t3");
        chk("t3_grant", 32'(grant_v[0]), 2);

        // ch3 has one byte, ch0 two: ch3 goes first from last_owner=2
        @(posedge clk);
        push_exp(0, 8'h33); push_exp(0, 8'h77);
        push_exp(0, 8'h30); push_exp(0, 8'h55); push_exp(0, 8'h56);
        push_acc(0, 3); push_acc(0, 0); push_acc(0, 0);
        push_src(0, 3, 8'h77);
        push_src(0, 0, 8'h55); push_src(0, 0, 8'h56);
        wait_idle(0, "t4");
        chk("t4_grant", 32'(grant_v[0]), 0);

        // reset while the tag frame is still on the wire
        @(posedge clk);
        push_exp(0, 8'h32); push_exp(0, 8'h32); push_exp(0, 8'h62); push_acc(0, 2);
        push_src(0, 2, 8'h62);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done_v[0] && n < BUDGET);
        chk("t6_frame_started", 32'(n < BUDGET), 1);
        repeat (5) @(negedge clk);
        rst_n_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_v[0] = 1'b1;
        @(negedge clk);
        chk("t6_busy_after_reset", 32'(busy_v[0]), 0);
        chk("t6_tx_data_after_reset", 32'(tx_data_v[0]), 0);
        chk("t6_grant_after_reset", 32'(grant_v[0]), 0);
        chk("t6_uart_still_busy", 32'(tx_done_v[0]), 0);
        wait_idle(0, "t6");
        chk("t6_grant", 32'(grant_v[0]), 2);

        // untagged instance, single-byte bursts alternate ch0/ch1
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 8'hA0 + 8'(i)); push_acc(1, 0);
            push_exp(1, 8'hB0 + 8'(i)); push_acc(1, 1);
            push_src(1, 0, 8'hA0 + 8'(i));
            push_src(1, 1, 8'hB0 + 8'(i));
        end
        wait_idle(1, "t5");
        chk("t5_grant", 32'(grant_v[1]), 1);

        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
